hazard_controller: RTL

Pipeline hazard sequencer for the 5-stage RISC-V core; it is the control companion to the E-stage operand forwarding logic. It detects load-use hazards and taken-branch flushes, and sequences the multi-cycle mul/div unit through a start/done handshake with a timeout watchdog. It drives the stall and flush enables of the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_controller_if.sv | 34 +++
 rtl/hazard_controller.sv | 108 ++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = pipeline side (drives hazard inputs), slave = hazard_controller.
interface hazard_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdE;
    logic        ResultSrcE0;
    logic        PCSrcE;
    logic        MulDivE;
    logic        MulDivDone;
    logic        MulDivStart;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushD;
    logic        FlushE;
    logic        FlushM;
    logic        MulDivErr;
    logic [31:0] LoadStallCnt;
    logic [31:0] MulDivStallCnt;
    logic [31:0] FlushCnt;

    modport master (
        output Rs1D, Rs2D, RdE, ResultSrcE0, PCSrcE, MulDivE, MulDivDone,
        input  MulDivStart, StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  MulDivErr, LoadStallCnt, MulDivStallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RdE, ResultSrcE0, PCSrcE, MulDivE, MulDivDone,
        output MulDivStart, StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output MulDivErr, LoadStallCnt, MulDivStallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / branch-flush hazard sequencer with mul/div start-done handshake and timeout watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | no mul/div in flight; a MulDivE issues the start pulse
// BUSY  | waiting for MulDivDone; watchdog counts stalled cycles
module hazard_controller #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic     clk,
    input  logic     reset_n,
    hazard_if.slave  hz
);
    localparam int CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          md_stall;
    logic          md_start;
    logic          lw_stall;
    logic          lw_stall_g;

    assign lw_stall   = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                        ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    assign lw_stall_g = lw_stall && !hz.PCSrcE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        md_stall = 1'b0;
        md_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.MulDivE) begin
                    md_start = 1'b1;
                    md_stall = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (hz.MulDivDone) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // watchdog expiry: let the instruction go with a bad result
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hz.MulDivStart = md_start;
    assign hz.MulDivErr   = err_q;
    assign hz.StallE      = md_stall;
    assign hz.FlushM      = md_stall;
    assign hz.StallF      = md_stall | lw_stall_g;
    assign hz.StallD      = md_stall | lw_stall_g;
    assign hz.FlushD      = hz.PCSrcE & ~md_stall;
    assign hz.FlushE      = (lw_stall_g | hz.PCSrcE) & ~md_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_cnt_q;
    logic [31:0] md_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt_q  <= 32'h0;
            md_cnt_q    <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (lw_stall_g && !md_stall) load_cnt_q  <= load_cnt_q + 32'h1;
            if (md_stall)                md_cnt_q    <= md_cnt_q + 32'h1;
            if (hz.PCSrcE && !md_stall)  flush_cnt_q <= flush_cnt_q + 32'h1;
        end
    end

    assign hz.LoadStallCnt   = load_cnt_q;
    assign hz.MulDivStallCnt = md_cnt_q;
    assign hz.FlushCnt       = flush_cnt_q;
`else
    assign hz.LoadStallCnt   = 32'h0;
    assign hz.MulDivStallCnt = 32'h0;
    assign hz.FlushCnt       = 32'h0;
`endif
endmodule
